// File: rtl/pipe_adder_pkg.sv
// ---------------------------------------------------------------------------
// pipe_adder_pkg
// Shared arithmetic helpers for the pipelined adder/subtractor.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

package pipe_adder_pkg;

  // One-bit full-add cell: returns {carry_out, sum}.
  function automatic logic [1:0] full_add(input logic x, input logic y, input logic c);
    return {(x & y) | (c & (x ^ y)), x ^ y ^ c};
  endfunction

endpackage

`default_nettype wire

// File: rtl/pipe_adder_stage.sv
// ---------------------------------------------------------------------------
// pipe_adder_stage
// One pipeline stage: CW-bit ripple chain over chunk K plus stage registers.
// Operands travel with the beat so later stages can consume their chunks;
// the partial sum accumulates finished chunks from the low end upward.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module pipe_adder_stage
  import pipe_adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CW    = 4,
  parameter int K     = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             adv_i,
  input  logic             vld_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [WIDTH-1:0] s_i,
  input  logic             c_i,
  output logic             vld_o,
  output logic [WIDTH-1:0] a_o,
  output logic [WIDTH-1:0] b_o,
  output logic [WIDTH-1:0] s_o,
  output logic             c_o,
  output logic             cmsb_o
);

  logic [CW:0]      carry;
  logic [WIDTH-1:0] s_d;
  logic             vld_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] s_q;
  logic             c_q;
  logic             cmsb_q;

  // Ripple chunk K through CW full-add cells and merge it into the partial sum.
  always_comb begin
    logic [1:0] fa;
    fa       = '0;
    carry    = '0;
    carry[0] = c_i;
    s_d      = s_i;
    for (int i = 0; i < CW; i++) begin
      fa           = full_add(a_i[K*CW+i], b_i[K*CW+i], carry[i]);
      s_d[K*CW+i]  = fa[0];
      carry[i+1]   = fa[1];
    end
  end

  // Stage occupancy follows the advance signal; a bubble simply moves in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= 1'b0;
    end else if (adv_i) begin
      vld_q <= vld_i;
    end
  end

  // Data loads only with a real beat, so it holds steady while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      s_q    <= '0;
      c_q    <= 1'b0;
      cmsb_q <= 1'b0;
    end else if (adv_i && vld_i) begin
      a_q    <= a_i;
      b_q    <= b_i;
      s_q    <= s_d;
      c_q    <= carry[CW];
      cmsb_q <= carry[CW-1];
    end
  end

  assign vld_o  = vld_q;
  assign a_o    = a_q;
  assign b_o    = b_q;
  assign s_o    = s_q;
  assign c_o    = c_q;
  assign cmsb_o = cmsb_q;

endmodule

`default_nettype wire

// File: rtl/pipe_adder.sv
// ---------------------------------------------------------------------------
// pipe_adder
// Pipelined ripple-carry adder/subtractor with valid/ready on both sides.
// WIDTH bits are added CW = WIDTH/STAGES bits per clock; full throughput,
// bubble-collapsing backpressure, latency STAGES.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module pipe_adder
  import pipe_adder_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CW = WIDTH / STAGES;

  logic [WIDTH-1:0]  b_cond;
  logic              c0;
  logic [STAGES-1:0] adv;
  logic [STAGES-1:0] vld_w;
  logic [STAGES-1:0] c_w;
  logic [STAGES-1:0] cmsb_w;
  logic [WIDTH-1:0]  a_w [STAGES];
  logic [WIDTH-1:0]  b_w [STAGES];
  logic [WIDTH-1:0]  s_w [STAGES];
  logic              unused_ok;

  // Subtraction is A + ~B + 1; the caller's carry-in is ignored then.
  assign b_cond = sub ? ~b : b;
  assign c0     = sub | cin;

  // Advance chain from the output back to the input: a stage moves when it
  // is empty or the stage after it moves.
  always_comb begin
    logic go;
    go  = out_ready;
    adv = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      go     = !vld_w[k] || go;
      adv[k] = go;
    end
  end

  assign in_ready = adv[0];

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic             vld_in;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic [WIDTH-1:0] s_in;
    logic             c_in;

    if (k == 0) begin : g_first
      assign vld_in = in_valid;
      assign a_in   = a;
      assign b_in   = b_cond;
      assign s_in   = '0;
      assign c_in   = c0;
    end else begin : g_next
      assign vld_in = vld_w[k-1];
      assign a_in   = a_w[k-1];
      assign b_in   = b_w[k-1];
      assign s_in   = s_w[k-1];
      assign c_in   = c_w[k-1];
    end

    pipe_adder_stage #(
      .WIDTH (WIDTH),
      .CW    (CW),
      .K     (k)
    ) u_stage (
      .clk    (clk),
      .rst_n  (rst_n),
      .adv_i  (adv[k]),
      .vld_i  (vld_in),
      .a_i    (a_in),
      .b_i    (b_in),
      .s_i    (s_in),
      .c_i    (c_in),
      .vld_o  (vld_w[k]),
      .a_o    (a_w[k]),
      .b_o    (b_w[k]),
      .s_o    (s_w[k]),
      .c_o    (c_w[k]),
      .cmsb_o (cmsb_w[k])
    );
  end

  assign out_valid = vld_w[STAGES-1];
  assign sum       = s_w[STAGES-1];
  assign cout      = c_w[STAGES-1];
  // Signed overflow: carry into the MSB disagrees with carry out of it.
  assign ovf       = cmsb_w[STAGES-1] ^ c_w[STAGES-1];

  // Fully consumed operands of the last stage and non-final MSB carries.
  assign unused_ok = ^{a_w[STAGES-1], b_w[STAGES-1], cmsb_w};

endmodule

`default_nettype wire

// File: tb/tb_pipe_adder.sv
// ---------------------------------------------------------------------------
// tb_pipe_adder
// Self-checking bench for pipe_adder (WIDTH=16, STAGES=4).
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_pipe_adder;

  localparam int W = 16;
  localparam int S = 4;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  int checks = 0;
  int errors = 0;
  logic [W+1:0] expq[$];

  pipe_adder #(.WIDTH(W), .STAGES(S)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: returns {ovf, cout, sum} from plain integer arithmetic.
  function automatic logic [W+1:0] ref_model(input logic [W-1:0] x, input logic [W-1:0] y,
                                             input logic ci, input logic s);
    logic [W-1:0] yy;
    logic         cc;
    logic [W:0]   full;
    int           sr;
    logic         of;
    yy   = s ? ~y : y;
    cc   = s ? 1'b1 : ci;
    full = {1'b0, x} + {1'b0, yy} + {{W{1'b0}}, cc};
    sr   = int'($signed(x)) + int'($signed(yy)) + int'(cc);
    of   = (sr > (2**(W-1)) - 1) || (sr < -(2**(W-1)));
    return {of, full[W], full[W-1:0]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare process: in_ready rule, idle output and in-order results.
  always @(negedge clk) begin
    if (rst_n) begin
      check("in_ready", {31'd0, in_ready}, {31'd0, (expq.size() < S) || out_ready});
      if (expq.size() == 0)
        check("idle_out_valid", {31'd0, out_valid}, 32'd0);
      else if (out_valid)
        check("result", {14'd0, ovf, cout, sum}, {14'd0, expq[0]});
      if (out_valid && out_ready && expq.size() > 0)
        void'(expq.pop_front());
      if (in_valid && in_ready)
        expq.push_back(ref_model(a, b, cin, sub));
    end
  end

  task automatic drain();
    int n;
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while ((expq.size() != 0 || out_valid) && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain", expq.size(), 32'd0);
  endtask

  task automatic directed(input string name, input logic [W-1:0] ta, input logic [W-1:0] tb,
                          input logic tc, input logic ts,
                          input logic [W-1:0] es, input logic ec, input logic eo);
    int lat;
    drain();
    in_valid = 1'b1; a = ta; b = tb; cin = tc; sub = ts;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check({name, "_latency"}, lat, S);
    check({name, "_sum"}, {16'd0, sum}, {16'd0, es});
    check({name, "_cout"}, {31'd0, cout}, {31'd0, ec});
    check({name, "_ovf"}, {31'd0, ovf}, {31'd0, eo});
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int i;
    int t;
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b0;

    // Pin the reference model with hand-computed values.
    check("model_add", {14'd0, ref_model(16'h1234, 16'h0FFF, 1'b0, 1'b0)}, {14'd0, 2'b00, 16'h2233});
    check("model_sub", {14'd0, ref_model(16'h8000, 16'h0001, 1'b0, 1'b1)}, {14'd0, 2'b11, 16'h7FFF});

    repeat (3) @(posedge clk);
    #1;
    check("reset_out_valid", {31'd0, out_valid}, 32'd0);
    check("reset_sum", {16'd0, sum}, 32'd0);
    check("reset_cout", {31'd0, cout}, 32'd0);
    check("reset_ovf", {31'd0, ovf}, 32'd0);
    rst_n = 1'b1;

    directed("add",     16'h1234, 16'h0FFF, 1'b0, 1'b0, 16'h2233, 1'b0, 1'b0);
    directed("ripple1", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    directed("ripple2", 16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
    directed("sub1",    16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    directed("sub2",    16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    directed("addovf",  16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    drain();

    // Backpressure: eight beats, out_ready low for four cycles mid-stream.
    i = 1;
    t = 0;
    while (i <= 8 && t < 100) begin
      out_ready = !(t >= 2 && t < 6);
      in_valid  = 1'b1;
      a = W'(i); b = W'(i << 8); cin = 1'b0; sub = 1'b0;
      @(negedge clk);
      if (in_ready) i++;
      t++;
      @(posedge clk); #1;
    end
    check("bp_stream_done", i, 9);
    drain();

    // Reset mid-stream with three beats in flight.
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1; a = W'(16'h1111 * (k + 1)); b = 16'h0101; cin = 1'b1; sub = 1'b0;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("pre_reset_valid", {31'd0, out_valid}, 32'd1);
    #2;
    rst_n = 1'b0;
    expq.delete();
    #1;
    check("async_rst_valid", {31'd0, out_valid}, 32'd0);
    check("async_rst_sum", {16'd0, sum}, 32'd0);
    check("async_rst_cout", {31'd0, cout}, 32'd0);
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check("post_reset_idle", {31'd0, out_valid}, 32'd0);
    directed("post_reset", 16'h00F0, 16'h0F10, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0);

    // Randomized traffic with random backpressure.
    for (int n = 0; n < 3000; n++) begin
      @(posedge clk); #1;
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      case ($urandom_range(0, 5))
        0: a = 16'hFFFF;
        1: a = 16'h8000;
        2: a = 16'h7FFF;
        3: a = 16'h0000;
        default: a = W'($urandom);
      endcase
      b   = ($urandom_range(0, 4) == 0) ? 16'h0001 : W'($urandom);
      cin = 1'($urandom_range(0, 1));
      sub = 1'($urandom_range(0, 1));
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
